des_xor_pipe: RTL and testbench
===============================

Name: des_xor_pipe

Overview:
Parametrised key-mixing stage for the DES round datapath; the successor of the fixed 48-bit single-register XOR stage.
- XORs the expanded half-block with the round subkey.
- Carries the result through STAGES registered pipeline stages with full valid/ready backpressure.
- Carries a round tag alongside the data and counts completed transfers.
- Sits between the E-expansion stage and the S-box substitution stage.

Parameters:
DATA_W, 48, width of data, key and result (legal: 1..64)
STAGES, 2, number of register stages from input to output (legal: 1..4)
TAG_W, 4, width of sideband tag (round index) carried with each word
CNT_W, 16, width of transfer counter

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
ext_data_in  input  DATA_W  expanded data word
key_data_in  input  DATA_W  round subkey
tag_in  input  TAG_W  round tag, travels with data
data_in_valid  input  1  input word valid
data_in_ready  output  1  stage can accept input this cycle
flush_in  input  1  synchronous pipeline flush
xor_data_out  output  DATA_W  ext ^ key result
tag_out  output  TAG_W  tag associated with xor_data_out
xor_data_out_valid  output  1  output word valid
xor_data_out_ready  input  1  downstream accepts output
busy_out  output  1  any stage holds a valid word
xfer_count_out  output  CNT_W  number of output transfers since reset/flush

Behaviour:
- Reset: rst_n_in is asynchronous, active-low; clock is clk_in. While in reset:
  - all stage valid bits = 0, all stage data/tag registers = 0;
  - xor_data_out = 0, tag_out = 0, xor_data_out_valid = 0, busy_out = 0, xfer_count_out = 0.
  - data_in_ready = 1 during and after reset, because the pipeline is empty.
- Input transfer: data_in_valid && data_in_ready at a rising edge. Stage 0 captures ext_data_in ^ key_data_in plus tag_in. The XOR is bitwise over DATA_W with no carry.
- Stage i ready rule: ready_i = !valid_i || ready_{i+1}. ready_STAGES = xor_data_out_ready. data_in_ready = ready_0 (combinational chain, no bubble).
- Stage advance: when ready_i = 1, stage i loads from stage i-1, including its valid bit. This produces a bubble when stage i-1 is empty.
- Stalled stage: a stage with valid=1 and ready=0 holds its data, tag and valid unchanged.
- Latency: exactly STAGES cycles from input transfer to xor_data_out_valid, with no stalls. Throughput is 1 word/cycle.
- Ordering: strict FIFO; no reordering, no drops, no duplication under any xor_data_out_ready pattern.
- Output: xor_data_out, tag_out and xor_data_out_valid come from the last stage. Data stays stable while valid && !ready.
- Output transfer: xor_data_out_valid && xor_data_out_ready. xfer_count_out increments by 1 per transfer and wraps from 2^CNT_W-1 to 0.
- flush_in (synchronous, priority over everything except reset):
  - next cycle: all valid bits = 0 and xfer_count_out = 0; data registers keep their values;
  - any input presented in the flush cycle is discarded;
  - data_in_ready is still driven by the ready rule during the flush cycle.
- Simultaneous input and output transfer with a full pipeline: accepted, and occupancy is unchanged.
- busy_out = OR of all stage valid bits (registered state, no comb path from inputs).
- Reset asserted mid-stream: in-flight words are lost, and outputs return immediately to their reset values.
- No X propagation: data registers load only on a valid advance.

Decomposition:
- Package des_pkg:
  - DES_EXP_W = 48;
  - DES_ROUND_W = 4;
  - typedef des_exp_t (logic [DES_EXP_W-1:0]);
  - typedef des_round_t (logic [DES_ROUND_W-1:0]).
  These serve as the defaults for DATA_W and TAG_W.
- Sub-module des_pipe_stage:
  - one register slice with valid, data and tag;
  - ports in_valid / in_ready / out_valid / out_ready and flush, parametrised by payload width;
  - des_xor_pipe instantiates STAGES of them in a generate loop, with the XOR at the stage-0 input.

Test Plan:
- Single word, no stall: ext=48'hFFFF_0000_FFFF, key=48'h0F0F_0F0F_0F0F, tag=4'h3, ready held 1 -> xor_data_out=48'hF0F0_0F0F_F0F0, tag_out=3, valid high exactly 2 cycles after input, for 1 cycle; xfer_count_out=1.
- Streaming: 16 back-to-back words (ext=i, key=48'hA5A5_A5A5_A5A5, tag=i) with ready=1 -> 16 consecutive output cycles, out=i^48'hA5A5_A5A5_A5A5 in order; data_in_ready never drops; count=16.
- Backpressure: stream with xor_data_out_ready deasserted 3 cycles mid-stream ->
  - pipeline fills to 2 words, then data_in_ready=0;
  - the output word is held stable;
  - after release, no loss or duplication, order intact.
- Full-pipe concurrency: pipeline full, in-valid=1 and out-ready=1 for 5 cycles -> 5 accepted, 5 delivered, busy_out stays 1, data_in_ready stays 1.
- Flush: 2 words in flight plus flush_in pulse with a concurrent input -> next cycle valid=0, busy_out=0, count=0; the flushed and concurrent words never appear at the output.
- Reset mid-operation: assert rst_n_in=0 with valid output held -> all outputs 0 immediately (async); after release, data_in_ready=1 and the first new word emerges after 2 cycles.

Source files
------------

// File: rtl/des_pkg.sv
// Shared widths and types for the DES round datapath.
package des_pkg;

  localparam int DES_EXP_W   = 48;
  localparam int DES_ROUND_W = 4;

  typedef logic [DES_EXP_W-1:0]   des_exp_t;
  typedef logic [DES_ROUND_W-1:0] des_round_t;

endpackage

// File: rtl/des_pipe_stage.sv
// One valid/ready register slice; ready looks through to the next slice so a
// full pipeline streams without bubbles.
module des_pipe_stage #(
  parameter int PAY_W = 52
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             in_valid,
  input  logic [PAY_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PAY_W-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [PAY_W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Payload only loads on a real word so empty slots never pull in X.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_in) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/des_xor_pipe.sv
// Key-mixing stage: ext ^ key enters a STAGES-deep valid/ready pipeline with
// the round tag riding alongside; completed output transfers are counted.
module des_xor_pipe
  import des_pkg::*;
#(
  parameter int DATA_W = DES_EXP_W,
  parameter int STAGES = 2,
  parameter int TAG_W  = DES_ROUND_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] ext_data_in,
  input  logic [DATA_W-1:0] key_data_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic              flush_in,
  output logic [DATA_W-1:0] xor_data_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              xor_data_out_valid,
  input  logic              xor_data_out_ready,
  output logic              busy_out,
  output logic [CNT_W-1:0]  xfer_count_out
);

  localparam int PAY_W = TAG_W + DATA_W;

  // Index 0 is the pipeline input, index STAGES the output.
  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [PAY_W-1:0] pay [STAGES+1];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign vld[0]        = data_in_valid;
  assign pay[0]        = {tag_in, ext_data_in ^ key_data_in};
  assign rdy[STAGES]   = xor_data_out_ready;
  assign data_in_ready = rdy[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    des_pipe_stage #(.PAY_W(PAY_W)) u_stage (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .flush_in  (flush_in),
      .in_valid  (vld[i]),
      .in_data   (pay[i]),
      .in_ready  (rdy[i]),
      .out_valid (vld[i+1]),
      .out_data  (pay[i+1]),
      .out_ready (rdy[i+1])
    );
  end

  assign xor_data_out       = pay[STAGES][DATA_W-1:0];
  assign tag_out            = pay[STAGES][PAY_W-1:DATA_W];
  assign xor_data_out_valid = vld[STAGES];
  assign busy_out           = |vld[STAGES:1];

  always_comb begin
    cnt_d = cnt_q;
    if (flush_in) begin
      cnt_d = '0;
    end else if (xor_data_out_valid && xor_data_out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign xfer_count_out = cnt_q;

endmodule

// File: tb/tb_des_xor_pipe.sv
// Bench for des_xor_pipe: a queue model of in-flight words pairs every output
// transfer with the word the spec says must come out next.
module tb_des_xor_pipe;

  localparam int DATA_W = 48;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 16;
  localparam int PAY_W  = TAG_W + DATA_W;
  localparam logic [DATA_W-1:0] KEY_A5 = 48'hA5A5_A5A5_A5A5;

  logic              clk_in;
  logic              rst_n_in;
  logic [DATA_W-1:0] ext_data_in;
  logic [DATA_W-1:0] key_data_in;
  logic [TAG_W-1:0]  tag_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic              flush_in;
  logic [DATA_W-1:0] xor_data_out;
  logic [TAG_W-1:0]  tag_out;
  logic              xor_data_out_valid;
  logic              xor_data_out_ready;
  logic              busy_out;
  logic [CNT_W-1:0]  xfer_count_out;

  des_xor_pipe #(
    .DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .ext_data_in        (ext_data_in),
    .key_data_in        (key_data_in),
    .tag_in             (tag_in),
    .data_in_valid      (data_in_valid),
    .data_in_ready      (data_in_ready),
    .flush_in           (flush_in),
    .xor_data_out       (xor_data_out),
    .tag_out            (tag_out),
    .xor_data_out_valid (xor_data_out_valid),
    .xor_data_out_ready (xor_data_out_ready),
    .busy_out           (busy_out),
    .xfer_count_out     (xfer_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  logic [PAY_W-1:0] exp_q[$];
  logic [PAY_W-1:0] pair_exp[$];
  logic [PAY_W-1:0] pair_got[$];
  logic [CNT_W-1:0] model_cnt = '0;

  // Reference model, sampled mid-cycle when all inputs are settled.
  always @(negedge clk_in) begin
    if (!rst_n_in || flush_in) begin
      exp_q.delete();
      model_cnt = '0;
    end else begin
      if (xor_data_out_valid && xor_data_out_ready) begin
        if (exp_q.size() > 0) pair_exp.push_back(exp_q.pop_front());
        else                  pair_exp.push_back('x);
        pair_got.push_back({tag_out, xor_data_out});
        model_cnt = model_cnt + 1'b1;
      end
      if (data_in_valid && data_in_ready)
        exp_q.push_back({tag_in, ext_data_in ^ key_data_in});
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_out) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clear_pairs();
    pair_exp.delete();
    pair_got.delete();
  endtask

  task automatic rand_word();
    ext_data_in = DATA_W'({$urandom(), $urandom()});
    key_data_in = DATA_W'({$urandom(), $urandom()});
    tag_in      = TAG_W'($urandom());
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({xor_data_out, tag_out, xor_data_out_valid, busy_out, xfer_count_out} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%h/%b/%b/%h expected all zero",
               xor_data_out, tag_out, xor_data_out_valid, busy_out, xfer_count_out);
    end
    n_vec++;
    if (data_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected 1", data_in_ready);
    end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    n_vec++;
    if (data_in_ready !== 1'b1 || xor_data_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got ready=%b valid=%b expected ready=1 valid=0",
               data_in_ready, xor_data_out_valid);
    end
  endtask

  task automatic test_single();
    int lat;
    clear_pairs();
    xor_data_out_ready = 1'b1;
    ext_data_in = 48'hFFFF_0000_FFFF;
    key_data_in = 48'h0F0F_0F0F_0F0F;
    tag_in = 4'h3;
    data_in_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      data_in_valid = 1'b0;
    end while (!xor_data_out_valid && lat < 10);
    n_vec++;
    if (lat != STAGES) begin
      n_err++;
      $display("FAIL single_latency: got %0d expected %0d", lat, STAGES);
    end
    n_vec++;
    if (xor_data_out !== 48'hF0F0_0F0F_F0F0 || tag_out !== 4'h3) begin
      n_err++;
      $display("FAIL single_data: got %h tag %h expected f0f00f0ff0f0 tag 3", xor_data_out, tag_out);
    end
    tick();
    n_vec++;
    if (xor_data_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_valid_width: got valid=%b expected 0", xor_data_out_valid);
    end
    n_vec++;
    if (xfer_count_out !== 16'd1 || pair_got.size() != 1) begin
      n_err++;
      $display("FAIL single_count: got %0d (%0d words) expected 1 (1 word)", xfer_count_out, pair_got.size());
    end
  endtask

  task automatic test_stream();
    int first, last, nout, drops;
    logic [CNT_W-1:0] exp_cnt;
    clear_pairs();
    exp_cnt = model_cnt + CNT_W'(16);
    first = -1; last = -1; nout = 0; drops = 0;
    xor_data_out_ready = 1'b1;
    for (int c = 0; c < 16 + STAGES + 4; c++) begin
      if (c < 16) begin
        data_in_valid = 1'b1;
        ext_data_in = DATA_W'(c);
        key_data_in = KEY_A5;
        tag_in = TAG_W'(c);
        if (!data_in_ready) drops++;
      end else begin
        data_in_valid = 1'b0;
      end
      if (xor_data_out_valid) begin
        nout++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    n_vec++;
    if (drops != 0) begin
      n_err++;
      $display("FAIL stream_ready: got %0d ready drops expected 0", drops);
    end
    n_vec++;
    if (nout != 16 || last - first + 1 != 16) begin
      n_err++;
      $display("FAIL stream_contig: got %0d outputs over %0d cycles expected 16 over 16", nout, last - first + 1);
    end
    n_vec++;
    if (pair_got.size() != 16) begin
      n_err++;
      $display("FAIL stream_size: got %0d words expected 16", pair_got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_vec++;
        if (pair_got[i] !== {TAG_W'(i), DATA_W'(i) ^ KEY_A5}) begin
          n_err++;
          $display("FAIL stream_word%0d: got %h expected %h", i, pair_got[i], {TAG_W'(i), DATA_W'(i) ^ KEY_A5});
        end
      end
    end
    n_vec++;
    if (xfer_count_out !== exp_cnt) begin
      n_err++;
      $display("FAIL stream_count: got %0d expected %0d", xfer_count_out, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] ext_a[12], key_a[12];
    logic [TAG_W-1:0]  tag_a[12];
    logic [PAY_W-1:0]  held;
    logic [CNT_W-1:0]  exp_cnt;
    bit acc, ok;
    int i;
    clear_pairs();
    exp_cnt = model_cnt + CNT_W'(12);
    for (int k = 0; k < 12; k++) begin
      rand_word();
      ext_a[k] = ext_data_in; key_a[k] = key_data_in; tag_a[k] = tag_in;
    end
    i = 0;
    held = '0;
    for (int c = 0; c < 60 && i < 12; c++) begin
      xor_data_out_ready = !(c >= 5 && c < 8);
      data_in_valid = 1'b1;
      ext_data_in = ext_a[i]; key_data_in = key_a[i]; tag_in = tag_a[i];
      #1;
      if (c == 5) held = {tag_out, xor_data_out};
      if (c == 6 || c == 7) begin
        n_vec++;
        if ({tag_out, xor_data_out} !== held || xor_data_out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL bp_hold_c%0d: got %h valid=%b expected %h valid=1", c, {tag_out, xor_data_out}, xor_data_out_valid, held);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (data_in_ready !== 1'b0 || busy_out !== 1'b1) begin
          n_err++;
          $display("FAIL bp_full: got ready=%b busy=%b expected ready=0 busy=1", data_in_ready, busy_out);
        end
      end
      acc = data_in_ready;
      tick();
      if (acc) i++;
    end
    data_in_valid = 1'b0;
    xor_data_out_ready = 1'b1;
    wait_drain(ok);
    n_vec++;
    if (!ok || pair_got.size() != 12) begin
      n_err++;
      $display("FAIL bp_drain: got %0d words drained=%0d expected 12 drained=1", pair_got.size(), ok);
    end else begin
      for (int k = 0; k < 12; k++) begin
        n_vec++;
        if (pair_got[k] !== {tag_a[k], ext_a[k] ^ key_a[k]}) begin
          n_err++;
          $display("FAIL bp_word%0d: got %h expected %h", k, pair_got[k], {tag_a[k], ext_a[k] ^ key_a[k]});
        end
      end
    end
    n_vec++;
    if (xfer_count_out !== exp_cnt) begin
      n_err++;
      $display("FAIL bp_count: got %0d expected %0d", xfer_count_out, exp_cnt);
    end
  endtask

  task automatic test_full_concurrency();
    int acc_n, del_n, guard;
    bit ok;
    clear_pairs();
    xor_data_out_ready = 1'b0;
    data_in_valid = 1'b1;
    rand_word();
    guard = 0;
    while (data_in_ready && guard < 10) begin
      tick();
      rand_word();
      guard++;
    end
    n_vec++;
    if (guard != STAGES || busy_out !== 1'b1) begin
      n_err++;
      $display("FAIL full_fill: got %0d accepted busy=%b expected %0d busy=1", guard, busy_out, STAGES);
    end
    xor_data_out_ready = 1'b1;
    acc_n = 0; del_n = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (data_in_ready !== 1'b1 || busy_out !== 1'b1) begin
        n_err++;
        $display("FAIL full_conc_c%0d: got ready=%b busy=%b expected 1/1", c, data_in_ready, busy_out);
      end
      if (data_in_valid && data_in_ready) acc_n++;
      if (xor_data_out_valid && xor_data_out_ready) del_n++;
      tick();
      rand_word();
    end
    n_vec++;
    if (acc_n != 5 || del_n != 5) begin
      n_err++;
      $display("FAIL full_conc_xfers: got in=%0d out=%0d expected 5/5", acc_n, del_n);
    end
    data_in_valid = 1'b0;
    wait_drain(ok);
    n_vec++;
    if (!ok || pair_got.size() != STAGES + 5 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_drain: got %0d words drained=%0d expected %0d drained=1", pair_got.size(), ok, STAGES + 5);
    end
    foreach (pair_got[k]) begin
      n_vec++;
      if (pair_got[k] !== pair_exp[k]) begin
        n_err++;
        $display("FAIL full_word%0d: got %h expected %h", k, pair_got[k], pair_exp[k]);
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    clear_pairs();
    xor_data_out_ready = 1'b0;
    // Two words fill the pipe, then flush with a word offered in the same cycle.
    for (int n = 1; n <= 2; n++) begin
      data_in_valid = 1'b1;
      rand_word();
      if (n == 1) begin
        // Single-word case first: input really is accepted-ready during flush.
        tick();
        data_in_valid = 1'b1;
        rand_word();
        flush_in = 1'b1;
        n_vec++;
        if (data_in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL flush1_ready: got %b expected 1", data_in_ready);
        end
      end else begin
        tick();
        rand_word();
        tick();
        rand_word();
        flush_in = 1'b1;
        n_vec++;
        if (data_in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL flush2_ready: got %b expected 0", data_in_ready);
        end
      end
      tick();
      flush_in = 1'b0;
      data_in_valid = 1'b0;
      n_vec++;
      if (xor_data_out_valid !== 1'b0 || busy_out !== 1'b0 || xfer_count_out !== '0) begin
        n_err++;
        $display("FAIL flush%0d_state: got valid=%b busy=%b count=%0d expected 0/0/0",
                 n, xor_data_out_valid, busy_out, xfer_count_out);
      end
      xor_data_out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
        if (xor_data_out_valid) seen++;
        tick();
      end
      n_vec++;
      if (seen != 0 || pair_got.size() != 0) begin
        n_err++;
        $display("FAIL flush%0d_leak: got %0d words out expected 0", n, pair_got.size());
      end
      xor_data_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int guard, lat;
    clear_pairs();
    xor_data_out_ready = 1'b0;
    data_in_valid = 1'b1;
    rand_word();
    tick();
    data_in_valid = 1'b0;
    guard = 0;
    while (!xor_data_out_valid && guard < 10) begin
      tick();
      guard++;
    end
    n_vec++;
    if (xor_data_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_setup: got valid=%b expected 1", xor_data_out_valid);
    end
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    n_vec++;
    if ({xor_data_out, tag_out, xor_data_out_valid, busy_out, xfer_count_out} !== '0 || data_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_async: got %h/%h/%b/%b/%h ready=%b expected zeros ready=1",
               xor_data_out, tag_out, xor_data_out_valid, busy_out, xfer_count_out, data_in_ready);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    #2;
    rst_n_in = 1'b1;
    tick();
    xor_data_out_ready = 1'b1;
    ext_data_in = 48'h1234_5678_9ABC;
    key_data_in = 48'h0000_FFFF_0000;
    tag_in = 4'hC;
    data_in_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      data_in_valid = 1'b0;
    end while (!xor_data_out_valid && lat < 10);
    n_vec++;
    if (lat != STAGES || xor_data_out !== 48'h1234_A987_9ABC || tag_out !== 4'hC) begin
      n_err++;
      $display("FAIL rstmid_first: got lat=%0d %h tag %h expected lat=%0d 1234a9879abc tag c",
               lat, xor_data_out, tag_out, STAGES);
    end
    tick();
    n_vec++;
    if (xfer_count_out !== 16'd1) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d expected 1", xfer_count_out);
    end
  endtask

  task automatic test_random();
    int i;
    bit acc, ok;
    logic [CNT_W-1:0] exp_cnt;
    clear_pairs();
    exp_cnt = model_cnt + CNT_W'(150);
    i = 0;
    rand_word();
    for (int c = 0; c < 2000 && i < 150; c++) begin
      data_in_valid = ($urandom_range(0, 3) != 0);
      xor_data_out_ready = ($urandom_range(0, 9) < 7);
      #1;
      acc = data_in_valid && data_in_ready;
      tick();
      if (acc) begin
        i++;
        rand_word();
      end
    end
    data_in_valid = 1'b0;
    xor_data_out_ready = 1'b1;
    wait_drain(ok);
    n_vec++;
    if (!ok || pair_got.size() != 150 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d words drained=%0d expected 150 drained=1", pair_got.size(), ok);
    end
    foreach (pair_got[k]) begin
      n_vec++;
      if (pair_got[k] !== pair_exp[k]) begin
        n_err++;
        $display("FAIL rand_word%0d: got %h expected %h", k, pair_got[k], pair_exp[k]);
      end
    end
    n_vec++;
    if (xfer_count_out !== exp_cnt) begin
      n_err++;
      $display("FAIL rand_count: got %0d expected %0d", xfer_count_out, exp_cnt);
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    ext_data_in = '0;
    key_data_in = '0;
    tag_in = '0;
    data_in_valid = 1'b0;
    flush_in = 1'b0;
    xor_data_out_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_concurrency();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
